// File: rtl/imm_encoder_pkg.sv
// imm_enc_pkg: shared types and constants for the immediate encoder.
//   imm_type_e  - immediate format selector (I, S, B, U, J, LI)
//   OPC_*       - opcodes the encoder generates on its own for LI expansion
//   enc_state_e - encoder FSM states
//   LIM_*       - signed range limits for the immediate checks
//   imm_legal() - range/alignment check used on request acceptance
// Optional feature macro: IMM_ENC_LI_EN (LI pseudo-op expansion).
package imm_enc_pkg;

  typedef enum logic [2:0] {
    IMM_I  = 3'b000,
    IMM_S  = 3'b001,
    IMM_B  = 3'b010,
    IMM_U  = 3'b011,
    IMM_J  = 3'b100,
    IMM_LI = 3'b101
  } imm_type_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

`ifdef IMM_ENC_LI_EN
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EMIT      = 2'd1,
    ST_EMIT_LUI  = 2'd2,
    ST_EMIT_ADDI = 2'd3
  } enc_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1
  } enc_state_e;
`endif

  localparam logic signed [31:0] LIM_I_MIN = -32'sd2048;
  localparam logic signed [31:0] LIM_I_MAX = 32'sd2047;
  localparam logic signed [31:0] LIM_B_MIN = -32'sd4096;
  localparam logic signed [31:0] LIM_B_MAX = 32'sd4094;
  localparam logic signed [31:0] LIM_J_MIN = -32'sd1048576;
  localparam logic signed [31:0] LIM_J_MAX = 32'sd1048574;

  // True when imm can be represented exactly in the selected format.
  function automatic logic imm_legal(input logic [2:0] imm_type, input logic [31:0] imm);
    logic signed [31:0] simm;
    logic ok;
    simm = $signed(imm);
    ok   = 1'b0;
    case (imm_type)
      IMM_I, IMM_S: ok = (simm >= LIM_I_MIN) && (simm <= LIM_I_MAX);
      IMM_B:        ok = (simm >= LIM_B_MIN) && (simm <= LIM_B_MAX) && !imm[0];
      IMM_J:        ok = (simm >= LIM_J_MIN) && (simm <= LIM_J_MAX) && !imm[0];
      IMM_U:        ok = (imm[11:0] == 12'h000);
`ifdef IMM_ENC_LI_EN
      // Any 32-bit value is reachable with LUI+ADDI.
      IMM_LI:       ok = 1'b1;
`endif
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request and instruction-stream signals of the encoder.
//   req_*    - decoded operation in, valid/ready handshake
//   instr_*  - encoded words out, valid/ready handshake, last marker
//   err      - one-cycle reject pulse
//   emit_cnt - count of handed-off words (CNT_W bits, wraps)
// Modports: slave = encoder side, master = requester/consumer side.
interface imm_encoder_if #(
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_imm_type;
  logic [31:0]      req_imm;
  logic [4:0]       req_rd;
  logic [4:0]       req_rs1;
  logic [4:0]       req_rs2;
  logic [2:0]       req_funct3;
  logic [6:0]       req_funct7;
  logic [6:0]       req_opcode;
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic             instr_last;
  logic             err;
  logic [CNT_W-1:0] emit_cnt;

  modport slave (
    input  req_valid, req_imm_type, req_imm, req_rd, req_rs1, req_rs2,
           req_funct3, req_funct7, req_opcode, instr_ready,
    output req_ready, instr_valid, instr, instr_last, err, emit_cnt
  );

  modport master (
    output req_valid, req_imm_type, req_imm, req_rd, req_rs1, req_rs2,
           req_funct3, req_funct7, req_opcode, instr_ready,
    input  req_ready, instr_valid, instr, instr_last, err, emit_cnt
  );
endinterface

// File: rtl/imm_field_pack.sv
// imm_field_pack: combinational RV32I word packer.
//   imm_type        in  format selector (I/S/B/U/J; anything else -> 0)
//   imm             in  immediate value
//   rd/rs1/rs2      in  register fields
//   funct3/funct7   in  function fields (funct7 only for OP-IMM shifts)
//   opcode          in  opcode field
//   word            out packed instruction word
module imm_field_pack
  import imm_enc_pkg::*;
(
  input  logic [2:0]  imm_type,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [6:0]  opcode,
  output logic [31:0] word
);

  // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
  logic       is_shift;
  logic [6:0] i_upper;

  assign is_shift = (opcode == OPC_OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));
  assign i_upper  = is_shift ? funct7 : imm[11:5];

  always_comb begin
    word = 32'h0;
    case (imm_type)
      IMM_I: word = {i_upper, imm[4:0], rs1, funct3, rd, opcode};
      IMM_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      IMM_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      IMM_U: word = {imm[31:12], rd, opcode};
      IMM_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = 32'h0;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: sequential RV32I immediate encoder.
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of imm_encoder_if (request in, word stream out,
//          err pulse, emit_cnt)
// A legal request produces one word (or an LUI/ADDI pair for LI) one cycle
// after acceptance; illegal requests pulse err and emit nothing.
// Optional feature macro: IMM_ENC_LI_EN enables LI expansion.
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  imm_encoder_if.slave bus
);

  enc_state_e       state_reg;
  logic [31:0]      instr_reg;
  logic             instr_valid_reg;
  logic             instr_last_reg;
  logic             err_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             req_legal;
  logic             hs;

  logic [2:0]       p0_type;
  logic [31:0]      p0_imm;
  logic [4:0]       p0_rs1;
  logic [4:0]       p0_rs2;
  logic [2:0]       p0_funct3;
  logic [6:0]       p0_funct7;
  logic [6:0]       p0_opcode;
  logic [31:0]      p0_word;

  assign req_legal = imm_legal(bus.req_imm_type, bus.req_imm);
  assign hs        = instr_valid_reg && bus.instr_ready;

`ifdef IMM_ENC_LI_EN
  logic        is_li;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic [31:0] p1_word;
  logic [31:0] addi_word_reg;

  // hi = (imm + 0x800) >> 12, computed on the upper bits only; the carry
  // out of bit 11 is exactly imm[11], and the sum wraps modulo 2^32.
  assign is_li = (bus.req_imm_type == IMM_LI);
  assign li_hi = bus.req_imm[31:12] + {19'd0, bus.req_imm[11]};
  assign li_lo = bus.req_imm[11:0];

  // First word: LUI when hi is non-zero, otherwise ADDI rd,x0,lo.
  assign p0_type   = !is_li ? bus.req_imm_type : (li_hi == 20'd0) ? IMM_I : IMM_U;
  assign p0_imm    = !is_li ? bus.req_imm : (li_hi == 20'd0) ? {20'd0, li_lo} : {li_hi, 12'd0};
  assign p0_rs1    = is_li ? 5'd0 : bus.req_rs1;
  assign p0_rs2    = is_li ? 5'd0 : bus.req_rs2;
  assign p0_funct3 = is_li ? 3'd0 : bus.req_funct3;
  assign p0_funct7 = is_li ? 7'd0 : bus.req_funct7;
  assign p0_opcode = !is_li ? bus.req_opcode : (li_hi == 20'd0) ? OPC_OP_IMM : OPC_LUI;

  // Second word of a pair: ADDI rd,rd,lo, captured at acceptance.
  imm_field_pack u_pack_addi (
    .imm_type (IMM_I),
    .imm      ({20'd0, li_lo}),
    .rd       (bus.req_rd),
    .rs1      (bus.req_rd),
    .rs2      (5'd0),
    .funct3   (3'd0),
    .funct7   (7'd0),
    .opcode   (OPC_OP_IMM),
    .word     (p1_word)
  );
`else
  assign p0_type   = bus.req_imm_type;
  assign p0_imm    = bus.req_imm;
  assign p0_rs1    = bus.req_rs1;
  assign p0_rs2    = bus.req_rs2;
  assign p0_funct3 = bus.req_funct3;
  assign p0_funct7 = bus.req_funct7;
  assign p0_opcode = bus.req_opcode;
`endif

  imm_field_pack u_pack_first (
    .imm_type (p0_type),
    .imm      (p0_imm),
    .rd       (bus.req_rd),
    .rs1      (p0_rs1),
    .rs2      (p0_rs2),
    .funct3   (p0_funct3),
    .funct7   (p0_funct7),
    .opcode   (p0_opcode),
    .word     (p0_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      instr_reg       <= 32'h0;
      instr_valid_reg <= 1'b0;
      instr_last_reg  <= 1'b0;
      err_reg         <= 1'b0;
      cnt_reg         <= '0;
`ifdef IMM_ENC_LI_EN
      addi_word_reg   <= 32'h0;
`endif
    end else begin
      err_reg <= 1'b0;
      if (hs) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end

      case (state_reg)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (!req_legal) begin
              err_reg <= 1'b1;
            end else begin
              instr_reg       <= p0_word;
              instr_valid_reg <= 1'b1;
`ifdef IMM_ENC_LI_EN
              addi_word_reg   <= p1_word;
              if (is_li) begin
                if (li_hi == 20'd0) begin
                  state_reg      <= ST_EMIT_ADDI;
                  instr_last_reg <= 1'b1;
                end else begin
                  // LUI alone is the whole expansion when lo is zero.
                  state_reg      <= ST_EMIT_LUI;
                  instr_last_reg <= (li_lo == 12'd0);
                end
              end else
`endif
              begin
                state_reg      <= ST_EMIT;
                instr_last_reg <= 1'b1;
              end
            end
          end
        end

        ST_EMIT: begin
          if (hs) begin
            instr_valid_reg <= 1'b0;
            instr_last_reg  <= 1'b0;
            state_reg       <= ST_IDLE;
          end
        end

`ifdef IMM_ENC_LI_EN
        ST_EMIT_LUI: begin
          if (hs) begin
            if (instr_last_reg) begin
              instr_valid_reg <= 1'b0;
              instr_last_reg  <= 1'b0;
              state_reg       <= ST_IDLE;
            end else begin
              instr_reg      <= addi_word_reg;
              instr_last_reg <= 1'b1;
              state_reg      <= ST_EMIT_ADDI;
            end
          end
        end

        ST_EMIT_ADDI: begin
          if (hs) begin
            instr_valid_reg <= 1'b0;
            instr_last_reg  <= 1'b0;
            state_reg       <= ST_IDLE;
          end
        end
`endif

        default: begin
          instr_valid_reg <= 1'b0;
          instr_last_reg  <= 1'b0;
          state_reg       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = (state_reg == ST_IDLE);
  assign bus.instr_valid = instr_valid_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_last  = instr_last_reg;
  assign bus.err         = err_reg;
  assign bus.emit_cnt    = cnt_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: table-driven check of imm_encoder with hand-computed words,
// plus directed sequences for stall, reset mid-pair and counter wrap.
// Built with a 4-bit emit counter so the wrap is reached quickly.
// Optional feature macro: IMM_ENC_LI_EN (LI vectors expect expansion).
module tb_imm_encoder;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  imm_encoder_if #(.CNT_W(CW)) bus ();

  imm_encoder #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  typ;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  opc;
    bit          e;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t          vecs[40];
  int            nv = 0;
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [2:0] t, input logic [31:0] imm,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] opc,
                     input bit e, input int nw, input logic [31:0] w0, input logic [31:0] w1);
    vecs[nv] = '{n, t, imm, rd, rs1, rs2, f3, f7, opc, e, nw, w0, w1};
    nv++;
  endtask

  // LI vectors: expansion when the feature is built in, a reject otherwise.
  task automatic add_li(input string n, input logic [31:0] imm, input logic [4:0] rd,
                        input int nw, input logic [31:0] w0, input logic [31:0] w1);
`ifdef IMM_ENC_LI_EN
    add(n, 3'b101, imm, rd, 5'd0, 5'd0, 3'd0, 7'd0, 7'h00, 1'b0, nw, w0, w1);
`else
    add(n, 3'b101, imm, rd, 5'd0, 5'd0, 3'd0, 7'd0, 7'h00, 1'b1, nw, w0, w1);
`endif
  endtask

  // Present a request for one cycle; returns #1 after the accepting edge.
  task automatic send(input vec_t v);
    chk({v.name, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_imm_type = v.typ;
    bus.req_imm      = v.imm;
    bus.req_rd       = v.rd;
    bus.req_rs1      = v.rs1;
    bus.req_rs2      = v.rs2;
    bus.req_funct3   = v.f3;
    bus.req_funct7   = v.f7;
    bus.req_opcode   = v.opc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    send(v);
    if (v.e) begin
      chk({v.name, "_err"}, {31'd0, bus.err}, 32'd1);
      chk({v.name, "_no_valid"}, {31'd0, bus.instr_valid}, 32'd0);
      chk({v.name, "_ready_kept"}, {31'd0, bus.req_ready}, 32'd1);
      @(posedge clk); #1;
      chk({v.name, "_err_pulse"}, {31'd0, bus.err}, 32'd0);
      chk({v.name, "_no_valid2"}, {31'd0, bus.instr_valid}, 32'd0);
      chk({v.name, "_cnt"}, {28'd0, bus.emit_cnt}, {28'd0, exp_cnt});
    end else begin
      chk({v.name, "_valid0"}, {31'd0, bus.instr_valid}, 32'd1);
      chk({v.name, "_word0"}, bus.instr, v.w0);
      chk({v.name, "_last0"}, {31'd0, bus.instr_last}, (v.nw == 1) ? 32'd1 : 32'd0);
      chk({v.name, "_busy"}, {31'd0, bus.req_ready}, 32'd0);
      bus.instr_ready = 1'b1;
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 1'b1;
      if (v.nw == 2) begin
        chk({v.name, "_valid1"}, {31'd0, bus.instr_valid}, 32'd1);
        chk({v.name, "_word1"}, bus.instr, v.w1);
        chk({v.name, "_last1"}, {31'd0, bus.instr_last}, 32'd1);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 1'b1;
      end
      bus.instr_ready = 1'b0;
      chk({v.name, "_done_valid"}, {31'd0, bus.instr_valid}, 32'd0);
      chk({v.name, "_done_ready"}, {31'd0, bus.req_ready}, 32'd1);
      chk({v.name, "_cnt"}, {28'd0, bus.emit_cnt}, {28'd0, exp_cnt});
    end
    $display("vec %s type=%b imm=%h words=%0d cnt=%0d", v.name, v.typ, v.imm,
             v.e ? 0 : v.nw, bus.emit_cnt);
  endtask

  task automatic chk_reset_outputs(input string n);
    chk({n, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    chk({n, "_instr"}, bus.instr, 32'd0);
    chk({n, "_last"}, {31'd0, bus.instr_last}, 32'd0);
    chk({n, "_err"}, {31'd0, bus.err}, 32'd0);
    chk({n, "_cnt"}, {28'd0, bus.emit_cnt}, 32'd0);
    chk({n, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  vec_t addi5;
  vec_t stall_v;

  initial begin
    bus.req_valid = 1'b0; bus.req_imm_type = 3'd0; bus.req_imm = 32'd0;
    bus.req_rd = 5'd0; bus.req_rs1 = 5'd0; bus.req_rs2 = 5'd0;
    bus.req_funct3 = 3'd0; bus.req_funct7 = 7'd0; bus.req_opcode = 7'd0;
    bus.instr_ready = 1'b0;

    //  name        type    imm           rd    rs1   rs2   f3    f7      opc     err nw w0            w1
    add("i_addi5",  3'b000, 32'd5,        5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 7'h13, 0, 1, 32'h00500093, 32'h0);
    add("b_m4",     3'b010, -32'sd4,      5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h63, 0, 1, 32'hFE000EE3, 32'h0);
    add("b_odd",    3'b010, 32'd3,        5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h63, 1, 0, 32'h0,        32'h0);
    add("i_2048",   3'b000, 32'd2048,     5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 7'h13, 1, 0, 32'h0,        32'h0);
    add("ill_111",  3'b111, 32'd0,        5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 7'h13, 1, 0, 32'h0,        32'h0);
    add("i_m2048",  3'b000, -32'sd2048,   5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 7'h13, 0, 1, 32'h80000093, 32'h0);
    add("i_2047",   3'b000, 32'd2047,     5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 7'h13, 0, 1, 32'h7FF00093, 32'h0);
    add("i_slli",   3'b000, 32'd3,        5'd1, 5'd2, 5'd0, 3'd1, 7'h00, 7'h13, 0, 1, 32'h00311093, 32'h0);
    add("i_srai",   3'b000, 32'd3,        5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 7'h13, 0, 1, 32'h40315093, 32'h0);
    add("i_lh",     3'b000, -32'sd1,      5'd1, 5'd2, 5'd0, 3'd1, 7'h20, 7'h03, 0, 1, 32'hFFF11083, 32'h0);
    add("s_sw",     3'b001, -32'sd8,      5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 7'h23, 0, 1, 32'hFE20AC23, 32'h0);
    add("u_lui",    3'b011, 32'hABCDE000, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 7'h37, 0, 1, 32'hABCDE1B7, 32'h0);
    add("u_low",    3'b011, 32'h00001001, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 7'h37, 1, 0, 32'h0,        32'h0);
    add("j_2048",   3'b100, 32'd2048,     5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 7'h6F, 0, 1, 32'h001000EF, 32'h0);
    add("j_min",    3'b100, 32'hFFF00000, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h6F, 0, 1, 32'h8000006F, 32'h0);
    add("j_over",   3'b100, 32'h00100000, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h6F, 1, 0, 32'h0,        32'h0);
    add("b_4094",   3'b010, 32'd4094,     5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h63, 0, 1, 32'h7E000FE3, 32'h0);
    add("b_m4096",  3'b010, -32'sd4096,   5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h63, 0, 1, 32'h80000063, 32'h0);
    add("b_4096",   3'b010, 32'd4096,     5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 7'h63, 1, 0, 32'h0,        32'h0);
    add_li("li_pair",  32'h12345FFF, 5'd5, 2, 32'h123462B7, 32'hFFF28293);
    add_li("li_small", 32'h00000123, 5'd5, 1, 32'h12300293, 32'h0);
    add_li("li_lui",   32'h12345000, 5'd5, 1, 32'h123452B7, 32'h0);
    add_li("li_zero",  32'h00000000, 5'd5, 1, 32'h00000293, 32'h0);
    add_li("li_neg",   32'hFFFFF800, 5'd5, 1, 32'h80000293, 32'h0);
    add_li("li_carry", 32'h00000800, 5'd5, 2, 32'h000012B7, 32'h80028293);

    addi5 = vecs[0];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < nv; i++) begin
      run_vec(vecs[i]);
    end

    // Stall: word held stable for 3 cycles with instr_ready low.
    stall_v = vecs[1];
    send(stall_v);
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("stall_word", bus.instr, 32'hFE000EE3);
      chk("stall_last", {31'd0, bus.instr_last}, 32'd1);
      chk("stall_ready", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.instr_ready = 1'b1;
    @(posedge clk); #1;
    bus.instr_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    chk("stall_done_cnt", {28'd0, bus.emit_cnt}, {28'd0, exp_cnt});
    $display("seq stall cnt=%0d", bus.emit_cnt);

    // Reset in the middle of a request (between LUI and ADDI when LI exists).
`ifdef IMM_ENC_LI_EN
    send(vecs[19]);
    chk("mid_lui", bus.instr, 32'h123462B7);
    bus.instr_ready = 1'b1;
    @(posedge clk); #1;
    bus.instr_ready = 1'b0;
    chk("mid_addi_pending", bus.instr, 32'hFFF28293);
`else
    send(addi5);
    chk("mid_word_pending", bus.instr, 32'h00500093);
`endif
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(posedge clk); #1;
    chk_reset_outputs("mid_reset_held");
    rst_n = 1'b1;
    exp_cnt = '0;
    @(posedge clk); #1;
    run_vec(addi5);
    $display("seq mid_reset cnt=%0d", bus.emit_cnt);

    // Counter wrap from all-ones to zero.
    for (int k = 0; k < 20 && exp_cnt != {CW{1'b1}}; k++) begin
      run_vec(addi5);
    end
    chk("cnt_all_ones", {28'd0, bus.emit_cnt}, 32'h0000000F);
    run_vec(addi5);
    chk("cnt_wrap", {28'd0, bus.emit_cnt}, 32'd0);
    $display("seq wrap cnt=%0d", bus.emit_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
